// File: rtl/pkt2uart_framer.sv
`default_nettype none
// ============================================================================
//  Module   : pkt2uart_framer
//  Purpose  : Transmit-side packet framer. Accepts a packet type and a
//             PD_LEN-byte payload in one handshake, then streams
//             START, type, length, payload (MSB byte first), checksum, END
//             one byte per output handshake toward the UART transmitter.
//  Revision : 1.0 - initial release
// ============================================================================
module pkt2uart_framer #(
  parameter int          PD_LEN     = 2,
  parameter logic [7:0]  START_BYTE = 8'hAA,
  parameter logic [7:0]  END_BYTE   = 8'h55
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            i_pkt_type,
  input  logic [8*PD_LEN-1:0]   i_pd,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [7:0]            o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_busy
);

  localparam int               CNT_W      = $clog2(PD_LEN) + 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(PD_LEN - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
  localparam logic [7:0]       c_len_byte = 8'(PD_LEN);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_TYPE  = 3'd2,
    S_LEN   = 3'd3,
    S_PD    = 3'd4,
    S_CHK   = 3'd5,
    S_END   = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [7:0]          r_type;
  logic [7:0]          r_chk;
  logic [8*PD_LEN-1:0] r_pd;
  logic [CNT_W-1:0]    r_pd_cnt;
  logic [7:0]          w_chk;
  logic                w_accept;
  logic                w_xfer;

  // Handshake qualifiers come from registered state only, so there is no
  // combinational path from i_ready/i_valid back into o_data.
  assign w_accept = (r_state == S_IDLE) && i_valid;
  assign w_xfer   = (r_state != S_IDLE) && i_ready;

  // Checksum of the incoming request: type ^ length ^ every payload byte.
  always_comb begin
    w_chk = i_pkt_type ^ c_len_byte;
    for (int i = 0; i < PD_LEN; i++) begin
      w_chk = w_chk ^ i_pd[i*8 +: 8];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Packet latch; the payload shifts left one byte per payload transfer so
  // the byte on the wire is always the top byte of r_pd.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_type   <= 8'h00;
      r_chk    <= 8'h00;
      r_pd     <= '0;
      r_pd_cnt <= '0;
    end else if (w_accept) begin
      r_type   <= i_pkt_type;
      r_chk    <= w_chk;
      r_pd     <= i_pd;
      r_pd_cnt <= '0;
    end else if ((r_state == S_PD) && w_xfer) begin
      r_pd     <= r_pd << 8;
      r_pd_cnt <= r_pd_cnt + c_cnt_one;
    end
  end

  // Next-state and output decode; every non-idle state advances only on a
  // completed output transfer.
  always_comb begin
    w_state_nxt = r_state;
    o_valid     = 1'b1;
    o_ready     = 1'b0;
    o_busy      = 1'b1;
    o_data      = 8'h00;
    case (r_state)
      S_IDLE: begin
        o_valid = 1'b0;
        o_ready = 1'b1;
        o_busy  = 1'b0;
        if (i_valid) w_state_nxt = S_START;
      end
      S_START: begin
        o_data = START_BYTE;
        if (w_xfer) w_state_nxt = S_TYPE;
      end
      S_TYPE: begin
        o_data = r_type;
        if (w_xfer) w_state_nxt = S_LEN;
      end
      S_LEN: begin
        o_data = c_len_byte;
        if (w_xfer) w_state_nxt = S_PD;
      end
      S_PD: begin
        o_data = r_pd[8*PD_LEN-1 -: 8];
        if (w_xfer && (r_pd_cnt == c_cnt_last)) w_state_nxt = S_CHK;
      end
      S_CHK: begin
        o_data = r_chk;
        if (w_xfer) w_state_nxt = S_END;
      end
      S_END: begin
        o_data = END_BYTE;
        if (w_xfer) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        o_valid     = 1'b0;
        o_busy      = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_pkt2uart_framer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pkt2uart_framer
//  Purpose  : Directed self-checking bench for pkt2uart_framer (PD_LEN=2 and
//             a PD_LEN=4 instance).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pkt2uart_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  i_pkt_type;
  logic [15:0] i_pd;
  logic        i_valid;
  logic        o_ready;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        i_ready;
  logic        o_busy;

  logic [7:0]  t4_type;
  logic [31:0] t4_pd;
  logic        t4_valid;
  logic        t4_ready_out;
  logic [7:0]  t4_data;
  logic        t4_valid_out;
  logic        t4_ready_in;
  logic        t4_busy;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          last_cycles;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp4 [9] = '{8'hAA, 8'h05, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h23, 8'h55};

  pkt2uart_framer #(.PD_LEN(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_pkt_type (i_pkt_type),
    .i_pd       (i_pd),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_busy     (o_busy)
  );

  pkt2uart_framer #(.PD_LEN(4)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .i_pkt_type (t4_type),
    .i_pd       (t4_pd),
    .i_valid    (t4_valid),
    .o_ready    (t4_ready_out),
    .o_data     (t4_data),
    .o_valid    (t4_valid_out),
    .i_ready    (t4_ready_in),
    .o_busy     (t4_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_chk(input logic [7:0] t, input logic [15:0] p);
    return t ^ 8'h02 ^ p[15:8] ^ p[7:0];
  endfunction

  task automatic push_pkt(input logic [7:0] t, input logic [15:0] p, input logic [7:0] c);
    exp_q.push_back(8'hAA);
    exp_q.push_back(t);
    exp_q.push_back(8'h02);
    exp_q.push_back(p[15:8]);
    exp_q.push_back(p[7:0]);
    exp_q.push_back(c);
    exp_q.push_back(8'h55);
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic send(input logic [7:0] t, input logic [15:0] p);
    int w;
    w = 0;
    i_pkt_type = t;
    i_pd       = p;
    i_valid    = 1'b1;
    while (!o_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("send_wait", 32'(w < 100), 32'd1);
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  // Consume up to nbytes expected bytes, checking every output cycle.
  task automatic drain(input bit rnd, input int nbytes, input string tag);
    int cyc;
    int got;
    cyc = 0;
    got = 0;
    while (exp_q.size() > 0 && got < nbytes && cyc < 400) begin
      i_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      check({tag, "_valid"}, 32'(o_valid), 32'd1);
      check({tag, "_busy"},  32'(o_busy),  32'd1);
      check({tag, "_ready"}, 32'(o_ready), 32'd0);
      check({tag, "_data"},  32'(o_data),  32'(exp_q[0]));
      if (i_ready) begin
        void'(exp_q.pop_front());
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, "_timeout"}, 32'(cyc < 400), 32'd1);
    last_cycles = cyc;
    i_ready = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_idle_valid"}, 32'(o_valid), 32'd0);
    check({tag, "_idle_ready"}, 32'(o_ready), 32'd1);
    check({tag, "_idle_busy"},  32'(o_busy),  32'd0);
  endtask

  initial begin
    logic [7:0]  rt;
    logic [15:0] rp;
    rst = 1'b1;
    i_pkt_type = 8'h00; i_pd = 16'h0000; i_valid = 1'b0; i_ready = 1'b0;
    t4_type = 8'h00; t4_pd = 32'h0; t4_valid = 1'b0; t4_ready_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state, and i_ready without a packet must not move anything.
    check_idle("reset");
    check("reset_data", 32'(o_data), 32'h00);
    i_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("ready_idle");
    check("ready_idle_data", 32'(o_data), 32'h00);
    i_ready = 1'b0;

    // Test 1: single packet, full-rate sink.
    push_pkt(8'h01, 16'h1234, 8'h25);
    send(8'h01, 16'h1234);
    drain(1'b0, 99, "t1");
    check("t1_cycles", 32'(last_cycles), 32'd7);
    check_idle("t1");

    // Test 2: same packet under random backpressure.
    push_pkt(8'h01, 16'h1234, 8'h25);
    send(8'h01, 16'h1234);
    drain(1'b1, 99, "t2");
    check_idle("t2");

    // Test 3: second request raised mid-packet waits for idle.
    push_pkt(8'h01, 16'h1234, 8'h25);
    send(8'h01, 16'h1234);
    drain(1'b0, 3, "t3a");
    i_pkt_type = 8'h7F;
    i_pd       = 16'hFFFF;
    i_valid    = 1'b1;
    drain(1'b1, 99, "t3a");
    check("t3_ready_at_idle", 32'(o_ready), 32'd1);
    @(negedge clk);
    i_valid = 1'b0;
    push_pkt(8'h7F, 16'hFFFF, 8'h7D);
    drain(1'b0, 99, "t3b");
    check_idle("t3b");

    // Test 4: asynchronous reset while in the payload phase.
    push_pkt(8'h01, 16'h1234, 8'h25);
    send(8'h01, 16'h1234);
    drain(1'b0, 3, "t4a");
    check("t4_pre_data", 32'(o_data), 32'h12);
    #2 rst = 1'b1;
    #1;
    check("t4_rst_valid", 32'(o_valid), 32'd0);
    check("t4_rst_ready", 32'(o_ready), 32'd1);
    check("t4_rst_busy",  32'(o_busy),  32'd0);
    check("t4_rst_data",  32'(o_data),  32'h00);
    #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_idle("t4_post");
    push_pkt(8'h10, 16'h0000, 8'h12);
    send(8'h10, 16'h0000);
    drain(1'b0, 99, "t4b");
    check_idle("t4b");

    // Test 5: back-to-back random packets with random sink readiness.
    for (int k = 0; k < 100; k++) begin
      rt = 8'($urandom);
      rp = 16'($urandom);
      push_pkt(rt, rp, model_chk(rt, rp));
      send(rt, rp);
      drain(1'b1, 99, "t5");
      check("t5_empty", 32'(exp_q.size()), 32'd0);
    end
    check_idle("t5");

    // Test 6: PD_LEN=4 instance.
    check("t6_reset_ready", 32'(t4_ready_out), 32'd1);
    t4_type  = 8'h05;
    t4_pd    = 32'hDEADBEEF;
    t4_valid = 1'b1;
    @(negedge clk);
    t4_valid    = 1'b0;
    t4_ready_in = 1'b1;
    for (int j = 0; j < 9; j++) begin
      check("t6_valid", 32'(t4_valid_out), 32'd1);
      check("t6_data",  32'(t4_data),      32'(exp4[j]));
      @(negedge clk);
    end
    check("t6_end_valid", 32'(t4_valid_out), 32'd0);
    check("t6_end_ready", 32'(t4_ready_out), 32'd1);
    check("t6_end_busy",  32'(t4_busy),      32'd0);
    t4_ready_in = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pkt2uart_framer.md
Name: pkt2uart_framer

Overview:
Transmit-side packet framer for the UART packet link. It accepts a packet type and a PD_LEN-byte payload in a single transaction. It then emits the framed byte stream one byte per handshake: START, type, length, payload, checksum, END. It sits between the command source and the byte-wide UART transmitter, and its output is byte-compatible with the link's receive parser.

Parameters:
PD_LEN, 2, payload length in bytes (>=1); also the value sent in the length byte (PD_LEN[7:0]).
START_BYTE, 8'hAA, first byte of every packet.
END_BYTE, 8'h55, last byte of every packet.

Ports:
clk  in  1  clock
rst  in  1  reset
i_pkt_type  in  8  packet type byte
i_pd  in  8*PD_LEN  payload; byte PD_LEN-1 (MSB byte) is transmitted first
i_valid  in  1  packet request
o_ready  out  1  framer can accept a packet
o_data  out  8  current output byte to UART TX
o_valid  out  1  o_data valid
i_ready  in  1  UART TX accepts o_data this cycle
o_busy  out  1  packet in flight (state != S_IDLE)

Behaviour:
- Reset: rst is asynchronous, active-high; clk is the clock. All state is clocked on posedge clk.
- Reset values: state=S_IDLE, o_valid=0, o_data=8'h00, o_ready=1, o_busy=0, all internal registers 0.
- Input handshake:
  - Accept occurs when i_valid && o_ready.
  - o_ready = (state==S_IDLE); it is a combinational function of state only and never depends on i_valid.
  - On accept, latch i_pkt_type and i_pd.
  - On accept, compute checksum = i_pkt_type ^ PD_LEN[7:0] ^ XOR of all PD_LEN payload bytes.
  - i_valid while busy is ignored; the request is held off by o_ready=0.
- Output handshake:
  - A byte transfers when o_valid && i_ready.
  - While o_valid && !i_ready, o_data and o_valid hold stable, with no skipping and no duplication.
  - o_valid=1 in every state except S_IDLE.
- FSM: S_IDLE -> S_START -> S_TYPE -> S_LEN -> S_PD -> S_CHK -> S_END -> S_IDLE. Every transition out of a non-idle state requires a transfer.
  - S_IDLE: on accept -> S_START.
  - S_START: o_data=START_BYTE.
  - S_TYPE: o_data=latched type.
  - S_LEN: o_data=PD_LEN[7:0].
  - S_PD: o_data=payload byte selected by counter pd_cnt ($clog2(PD_LEN)+1 bits, cleared on accept).
    - Byte order is most significant first: byte index PD_LEN-1-pd_cnt.
    - pd_cnt increments per transfer; on the transfer with pd_cnt==PD_LEN-1 -> S_CHK.
  - S_CHK: o_data=checksum.
  - S_END: o_data=END_BYTE; on transfer -> S_IDLE.
- o_data is registered, or decoded from registered state/counter only; it has no combinational path from i_ready or i_valid.
- Latency:
  - Accept in cycle N puts START on o_data with o_valid=1 in cycle N+1.
  - With i_ready held at 1, a packet occupies PKTLEN=PD_LEN+5 consecutive output cycles.
  - One S_IDLE cycle separates back-to-back packets, so minimum packet period is PD_LEN+6 cycles.
- Boundaries:
  - PD_LEN=1: S_PD lasts exactly one transfer.
  - i_ready stuck low: the block holds the current byte indefinitely, with no timeout.
  - i_ready high while o_valid=0 has no effect.
- Reset mid-packet: async return to S_IDLE; o_valid drops immediately; the partial packet is abandoned with no END_BYTE; o_ready=1 after reset release.
- The checksum is 8-bit XOR with no carry.

Test Plan:
1. Single packet, PD_LEN=2, type=0x01, pd=0x1234, i_ready=1 -> o_data sequence AA 01 02 12 34 25 55 on 7 consecutive cycles starting 1 cycle after accept; o_ready=0 throughout, then 1.
2. Backpressure: same packet, i_ready pseudo-random (~50%) -> exactly the 7 bytes AA 01 02 12 34 25 55, none repeated or dropped; o_data stable whenever o_valid && !i_ready.
3. Request while busy: second i_valid (type=0x7F, pd=0xFFFF) held from mid-packet -> ignored until S_IDLE, then accepted. Second stream is AA 7F 02 FF FF 7D 55 (7F^02^FF^FF=7D), and the first packet is uncorrupted.
4. Reset mid-packet: assert rst asynchronously during S_PD -> o_valid=0 the same cycle, o_ready=1. A new packet (type=0x10, pd=0x0000) then produces AA 10 02 00 00 12 55.
5. Loopback into the link receive parser, back-to-back 100 random packets with random i_ready -> the parser pulses its valid once per packet and its o_data equals {55, chk, pd, 02, type, AA}.
6. PD_LEN=4 build, type=0x05, pd=0xDEADBEEF -> AA 05 04 DE AD BE EF 23 55.
